// File: rtl/mymac_iter.sv
// Iterative 16x16 signed/unsigned multiply-accumulate on the openMSP430 peripheral bus.
// Optional level interrupt enabled by defining MYMAC_IRQ_EN.
module mymac_iter #(
  parameter logic [13:0] BASE_ADDR  = 14'h0A0,
  parameter int          RADIX_LOG2 = 0,
  parameter int          ACC_GUARD  = 8
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic        irq
);

  localparam int         ACC_W    = 32 + ACC_GUARD;
  localparam int         DIG_W    = 1 << RADIX_LOG2;
  localparam int         N_DIG    = 16 >> RADIX_LOG2;
  localparam logic [4:0] CNT_LAST = 5'(N_DIG - 1);

  localparam logic [2:0] R_OPA  = 3'd0;
  localparam logic [2:0] R_OPB  = 3'd1;
  localparam logic [2:0] R_RES0 = 3'd2;
  localparam logic [2:0] R_RES1 = 3'd3;
  localparam logic [2:0] R_RES2 = 3'd4;
  localparam logic [2:0] R_CTL  = 3'd5;
  localparam logic [2:0] R_STAT = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ACC} state_e;

  state_e             state_q, state_d;
  logic [15:0]        opa_q, opa_d, opb_q, opb_d;
  logic               signed_q, signed_d, mac_q, mac_d, auto_q, auto_d;
  logic               done_q, done_d, ovf_q, ovf_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [31:0]        mcand_q, mcand_d, partial_q, partial_d;
  logic [15:0]        mplier_q, mplier_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               neg_q, neg_d, op_signed_q, op_signed_d, op_mac_q, op_mac_d;

  // Bus decode
  logic       hit, wr_en, rd_en;
  logic [2:0] off;
  logic       wr_opa, wr_opb, wr_ctl, wr_stat;

  assign hit     = (per_addr >= BASE_ADDR) && (per_addr <= BASE_ADDR + 14'd6);
  assign off     = 3'(per_addr - BASE_ADDR);
  assign wr_en   = per_en && (per_we == 2'b11) && hit;
  assign rd_en   = per_en && (per_we == 2'b00) && hit;
  assign wr_opa  = wr_en && (off == R_OPA);
  assign wr_opb  = wr_en && (off == R_OPB);
  assign wr_ctl  = wr_en && (off == R_CTL);
  assign wr_stat = wr_en && (off == R_STAT);

  logic start_ctl, start_auto, start, clr, busy;
  assign start_ctl  = wr_ctl && per_din[0];
  assign start_auto = wr_opb && auto_q;
  assign start      = (start_ctl || start_auto) && (state_q == S_IDLE);
  assign clr        = wr_ctl && per_din[4];
  assign busy       = (state_q != S_IDLE);

  // Operand capture: an AUTO start uses the OPB value being written this cycle.
  logic [15:0] src_a, src_b, mag_a, mag_b;
  logic        src_signed, src_mac;
  assign src_a      = opa_q;
  assign src_b      = start_auto ? per_din : opb_q;
  assign src_signed = start_ctl ? per_din[1] : signed_q;
  assign src_mac    = start_ctl ? per_din[2] : mac_q;
  assign mag_a      = (src_signed && src_a[15]) ? (~src_a + 16'd1) : src_a;
  assign mag_b      = (src_signed && src_b[15]) ? (~src_b + 16'd1) : src_b;

  // Final product and accumulation
  logic [DIG_W-1:0] digit;
  logic [31:0]      prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum;
  logic             add_ovf;

  assign digit = mplier_q[DIG_W-1:0];
  assign prod  = neg_q ? (~partial_q + 32'd1) : partial_q;
  assign sum   = {1'b0, acc_q} + {1'b0, prod_ext};

  always_comb begin
    prod_ext = ACC_W'(prod);
    if (op_signed_q) prod_ext = ACC_W'($signed(prod));
  end

  assign add_ovf = op_signed_q
                 ? ((acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]))
                 : sum[ACC_W];

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    signed_d    = signed_q;
    mac_d       = mac_q;
    auto_d      = auto_q;
    done_d      = done_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    partial_d   = partial_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    op_signed_d = op_signed_q;
    op_mac_d    = op_mac_q;

    if (wr_opa) opa_d = per_din;
    if (wr_opb) opb_d = per_din;
    if (wr_ctl) begin
      signed_d = per_din[1];
      mac_d    = per_din[2];
      auto_d   = per_din[3];
    end
    if (clr) acc_d = '0;
    if (wr_stat && per_din[1]) done_d = 1'b0;
    if (wr_stat && per_din[2]) ovf_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d     = {16'h0, mag_a};
          mplier_d    = mag_b;
          neg_d       = src_signed && (src_a[15] ^ src_b[15]);
          op_signed_d = src_signed;
          op_mac_d    = src_mac;
          partial_d   = '0;
          cnt_d       = '0;
          done_d      = 1'b0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        partial_d = partial_q + (mcand_q * 32'(digit));
        mcand_d   = mcand_q << DIG_W;
        mplier_d  = mplier_q >> DIG_W;
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) state_d = S_ACC;
      end
      S_ACC: begin
        // A simultaneous CLR clears first, so the product lands in an empty accumulator.
        if (op_mac_q && !clr) begin
          acc_d = sum[ACC_W-1:0];
          if (add_ovf) ovf_d = 1'b1;
        end else begin
          acc_d = prod_ext;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state, datapath included, is reset so an aborted operation leaves nothing behind.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q     <= S_IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      signed_q    <= 1'b0;
      mac_q       <= 1'b0;
      auto_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      partial_q   <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      op_signed_q <= 1'b0;
      op_mac_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      signed_q    <= signed_d;
      mac_q       <= mac_d;
      auto_q      <= auto_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      partial_q   <= partial_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      op_signed_q <= op_signed_d;
      op_mac_q    <= op_mac_d;
    end
  end

  logic ie_rd;

`ifdef MYMAC_IRQ_EN
  logic ie_q, ie_d, irq_q;

  always_comb begin
    ie_d = ie_q;
    if (wr_ctl) ie_d = per_din[5];
  end

  // Registered from next-state values so irq tracks DONE & IE with no extra lag.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= done_d && ie_d;
    end
  end

  assign ie_rd = ie_q;
  assign irq   = irq_q;
`else
  assign ie_rd = 1'b0;
  assign irq   = 1'b0;
`endif

  logic [15:0] res2;
  always_comb begin
    res2 = '0;
    if (ACC_GUARD != 0) begin
      if (signed_q) res2 = 16'($signed(acc_q) >>> 32);
      else          res2 = 16'(acc_q >> 32);
    end
  end

  always_comb begin
    per_dout = 16'h0;
    if (rd_en) begin
      unique case (off)
        R_OPA:   per_dout = opa_q;
        R_OPB:   per_dout = opb_q;
        R_RES0:  per_dout = acc_q[15:0];
        R_RES1:  per_dout = acc_q[31:16];
        R_RES2:  per_dout = res2;
        R_CTL:   per_dout = {10'h0, ie_rd, 1'b0, auto_q, mac_q, signed_q, 1'b0};
        R_STAT:  per_dout = {13'h0, ovf_q, done_q, busy};
        default: per_dout = 16'h0;
      endcase
    end
  end

endmodule
